// File: rtl/sd_data_block_receiver_pkg.sv
// Shared SD SPI-mode definitions: receiver states, start token, CRC16 constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package sd_data_block_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TOKEN,
    ST_RECV_DATA,
    ST_RECV_CRC,
    ST_FINISH,
    ST_FAIL
  } sd_rx_state_t;

  localparam logic [7:0]  SD_START_TOKEN = 8'hFE;
  localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

  // One serial step of CRC16-CCITT: shift left, fold in the polynomial when
  // the outgoing MSB differs from the incoming bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? SD_CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_data_block_receiver_if.sv
// Bundle between the SD data line/command sequencer and the block receiver.
// Latency: n/a (wiring only).
// Backpressure: none; every data strobe must be consumed by the sink.
// Ports: sd_do/activate flow into the receiver; data/data_valid/byte_index,
// crc/crc_ok, done/timeout/busy flow out of it.
interface sd_data_block_receiver_if;
  logic        sd_do;
  logic        activate;
  logic [7:0]  data;
  logic        data_valid;
  logic [8:0]  byte_index;
  logic [15:0] crc;
  logic        crc_ok;
  logic        done;
  logic        timeout;
  logic        busy;

  modport master (
    output sd_do, activate,
    input  data, data_valid, byte_index, crc, crc_ok, done, timeout, busy
  );

  modport slave (
    input  sd_do, activate,
    output data, data_valid, byte_index, crc, crc_ok, done, timeout, busy
  );
endinterface

// File: rtl/sd_data_block_receiver_crc16_serial.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), initial value 0, no final XOR.
// Latency: result includes a bit one falling edge after it is presented with en=1.
// Backpressure: none; clr is synchronous and wins over en.
// Ports: clk, rst_n, clr, en, bit_in in; crc[15:0] out.
module sd_crc16_serial
  import sd_data_block_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_data_block_receiver.sv
// SPI-mode SD single-block read receiver: hunts the 0xFE token, deserialises the block, checks CRC16.
// Latency: byte n strobes in the cycle after the 8th bit of that byte; done one cycle after CRC bit 15.
// Backpressure: none; one byte per 8 clocks, the sink must accept every data_valid.
// Ports: clk (state updates on falling edge), rst_n async active-low,
// sd (slave modport): sd_do/activate in; data/data_valid/byte_index, crc/crc_ok, done/timeout/busy out.
module sd_data_block_receiver
  import sd_data_block_receiver_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int WAIT_LIMIT  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sd_data_block_receiver_if.slave sd
);

  localparam int              WAIT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [8:0]      BYTE_LAST = 9'(BLOCK_BYTES - 1);

  sd_rx_state_t      state, state_nxt;
  logic [7:0]        sreg;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        byte_cnt;
  logic [3:0]        bit_cnt;
  logic [7:0]        data_r;
  logic [8:0]        byte_index_r;
  logic              data_valid_r;
  logic [15:0]       crc_r;
  logic              crc_ok_r;
  logic [15:0]       engine_crc;
  logic              crc_clr, crc_en;
  logic              done_c, timeout_c, busy_c;

  // Shift values including the bit sampled on this edge; token match and the
  // final CRC compare both need to see the incoming bit, not last edge's view.
  logic [7:0]  shift_val;
  logic [15:0] crc_shift;
  assign shift_val = {sreg[6:0], sd.sd_do};
  assign crc_shift = {crc_r[14:0], sd.sd_do};

  sd_crc16_serial u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (sd.sd_do),
    .crc    (engine_crc)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    busy_c    = 1'b1;
    case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (sd.activate) begin
          state_nxt = ST_WAIT_TOKEN;
          crc_clr   = 1'b1;
        end
      end
      ST_WAIT_TOKEN: begin
        // Token match outranks the timeout on the same edge.
        if (shift_val == SD_START_TOKEN) begin
          state_nxt = ST_RECV_DATA;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_FAIL;
        end
      end
      ST_RECV_DATA: begin
        crc_en = 1'b1;
        if (bit_cnt == 4'd7 && byte_cnt == BYTE_LAST) begin
          state_nxt = ST_RECV_CRC;
        end
      end
      ST_RECV_CRC: begin
        if (bit_cnt == 4'd15) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_FAIL: begin
        timeout_c = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg         <= '0;
      wait_cnt     <= '0;
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      data_r       <= '0;
      byte_index_r <= '0;
      data_valid_r <= 1'b0;
      crc_r        <= '0;
      crc_ok_r     <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sd.activate) begin
            sreg     <= '0;
            wait_cnt <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            crc_r    <= '0;
            crc_ok_r <= 1'b0;
          end
        end
        ST_WAIT_TOKEN: begin
          sreg     <= shift_val;
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_RECV_DATA: begin
          sreg <= shift_val;
          if (bit_cnt == 4'd7) begin
            data_r       <= shift_val;
            byte_index_r <= byte_cnt;
            data_valid_r <= 1'b1;
            byte_cnt     <= byte_cnt + 9'd1;
            bit_cnt      <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_RECV_CRC: begin
          // bit_cnt wraps 15 -> 0 here, leaving it clean for the next block.
          crc_r   <= crc_shift;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            crc_ok_r <= (crc_shift == engine_crc);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sd.data       = data_r;
  assign sd.data_valid = data_valid_r;
  assign sd.byte_index = byte_index_r;
  assign sd.crc        = crc_r;
  assign sd.crc_ok     = crc_ok_r;
  assign sd.done       = done_c;
  assign sd.timeout    = timeout_c;
  assign sd.busy       = busy_c;

endmodule

// File: tb/tb_sd_data_block_receiver.sv
// Bench for sd_data_block_receiver: two instances (512-byte and 4-byte blocks),
// stimulus pushes expected events into per-instance queues, monitors pop and compare.
// Expected events come from a stream-level model (token search, byte slicing, CRC).
module tb_sd_data_block_receiver;

  localparam int A_BYTES = 512;
  localparam int A_WAIT  = 4096;
  localparam int B_BYTES = 4;
  localparam int B_WAIT  = 64;

  typedef struct {
    int kind;    // 0 data strobe, 1 done, 2 timeout
    int edge_n;  // falling-edge count after which the output is high
    int a;       // data: byte index, done: crc_ok
    int b;       // data: byte value, done: crc
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ecnt = 0;
  int   tests = 0;
  int   fails = 0;
  evt_t qa[$];
  evt_t qb[$];
  bit   sbits[$];

  always #5 clk = ~clk;
  always @(negedge clk) ecnt++;

  sd_data_block_receiver_if ifa ();
  sd_data_block_receiver_if ifb ();

  sd_data_block_receiver #(.BLOCK_BYTES(A_BYTES), .WAIT_LIMIT(A_WAIT)) dut_a (
    .clk(clk), .rst_n(rst_n), .sd(ifa));
  sd_data_block_receiver #(.BLOCK_BYTES(B_BYTES), .WAIT_LIMIT(B_WAIT)) dut_b (
    .clk(clk), .rst_n(rst_n), .sd(ifb));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic logic [63:0] sig(input int kind, input int edge_n, input int a, input int b);
    return {kind[3:0], edge_n[27:0], a[15:0], b[15:0]};
  endfunction

  // {data, byte_index, crc, crc_ok, data_valid, done, timeout, busy}
  function automatic logic [37:0] outs(input int w);
    if (w != 0)
      return {ifb.data, ifb.byte_index, ifb.crc, ifb.crc_ok, ifb.data_valid, ifb.done, ifb.timeout, ifb.busy};
    return {ifa.data, ifa.byte_index, ifa.crc, ifa.crc_ok, ifa.data_valid, ifa.done, ifa.timeout, ifa.busy};
  endfunction

  function automatic int qsize(input int w);
    return (w != 0) ? qb.size() : qa.size();
  endfunction

  task automatic push(input int w, input evt_t e);
    if (w != 0) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic set_act(input int w, input logic v);
    if (w != 0) ifb.activate = v; else ifa.activate = v;
  endtask

  task automatic set_do(input int w, input logic v);
    if (w != 0) ifb.sd_do = v; else ifa.sd_do = v;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc16_ref(input logic [7:0] bytes[$]);
    logic [15:0] c = 16'h0000;
    foreach (bytes[i])
      for (int k = 7; k >= 0; k--)
        c = (c[15] ^ bytes[i][k]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // Eight stream bits starting at p, MSB first; the line idles high past the end.
  function automatic logic [7:0] win(input int p);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 8; k++)
      r = {r[6:0], ((p + k) < sbits.size()) ? sbits[p + k] : 1'b1};
    return r;
  endfunction

  // Hunt starts with stream bit 'start' sampled on edge e0+start+1.
  task automatic model(input int w, input int start, input int e0, input int keep, output int end_edge);
    int nb, wl, found, t, p0;
    logic [7:0] d[$];
    logic [15:0] rc, cc;
    nb = (w != 0) ? B_BYTES : A_BYTES;
    wl = (w != 0) ? B_WAIT : A_WAIT;
    found = -1;
    for (int j = 7; j < wl; j++)
      if (win(start + j - 7) == 8'hFE) begin found = j; break; end
    if (found < 0) begin
      end_edge = e0 + start + wl;
      push(w, '{2, end_edge, 0, 0});
    end else begin
      t  = e0 + start + 1 + found;
      p0 = start + found + 1;
      for (int n = 0; n < nb; n++) begin
        d.push_back(win(p0 + 8 * n));
        if (keep < 0 || n <= keep) push(w, '{0, t + 8 * (n + 1), n, int'(d[n])});
      end
      rc = {win(p0 + 8 * nb), win(p0 + 8 * nb + 8)};
      cc = crc16_ref(d);
      end_edge = t + 8 * nb + 16;
      if (keep < 0) push(w, '{1, end_edge, int'(rc == cc), int'(rc)});
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int w);
    logic [37:0] o;
    logic [63:0] act;
    evt_t e;
    o = outs(w);
    if (o[3] | o[2] | o[1]) begin
      if (o[3])      act = sig(0, ecnt, int'(o[29:21]), int'(o[37:30]));
      else if (o[2]) act = sig(1, ecnt, int'(o[4]), int'(o[20:5]));
      else           act = sig(2, ecnt, 0, 0);
      if (qsize(w) == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event inst%0d: got %h, required no event", w, act);
      end else begin
        if (w != 0) e = qb.pop_front(); else e = qa.pop_front();
        chk((w != 0) ? "event_b" : "event_a", act, sig(e.kind, e.edge_n, e.a, e.b));
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic put_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) sbits.push_back(b[k]);
  endtask

  task automatic put_block(input int pre_ff, input logic [7:0] bytes[$], input logic [15:0] crc_flip);
    repeat (pre_ff) put_byte(8'hFF);
    put_byte(8'hFE);
    foreach (bytes[i]) put_byte(bytes[i]);
    put_byte(crc16_ref(bytes)[15:8] ^ crc_flip[15:8]);
    put_byte(crc16_ref(bytes)[7:0] ^ crc_flip[7:0]);
  endtask

  task automatic start(input int w, input bit hold, output int e0);
    @(posedge clk);
    set_act(w, 1'b1);
    @(posedge clk);
    e0 = ecnt;
    if (!hold) set_act(w, 1'b0);
  endtask

  task automatic drive(input int w, input int abort_idx, input int probe_edge);
    logic [37:0] o;
    foreach (sbits[i]) begin
      set_do(w, sbits[i]);
      @(posedge clk);
      o = outs(w);
      if (probe_edge >= 0 && ecnt == probe_edge)     chk("b2b_idle_gap", o[0], 1'b0);
      if (probe_edge >= 0 && ecnt == probe_edge + 1) chk("b2b_rehunt",   o[0], 1'b1);
      if (abort_idx >= 0 && o[3] && int'(o[29:21]) == abort_idx) begin
        #1 rst_n = 1'b0;
        #1 chk("reset_outputs_zero", outs(w), 38'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
    end
    set_do(w, 1'b1);
  endtask

  task automatic drain(input int w, input string nm);
    for (int c = 0; c < 6000 && qsize(w) != 0; c++) @(posedge clk);
    chk({nm, "_pending"}, qsize(w), 0);
    repeat (2) @(posedge clk);
    chk({nm, "_busy_low"}, outs(w) & 38'h1, 38'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d1, s2, dummy, pre, ffcnt;
    logic [7:0] dq[$];
    logic [15:0] flip;

    ifa.activate = 1'b0; ifa.sd_do = 1'b1;
    ifb.activate = 1'b0; ifb.sd_do = 1'b1;
    repeat (3) @(posedge clk);
    chk("reset_state_a", outs(0), 38'h0);
    chk("reset_state_b", outs(1), 38'h0);
    #1 rst_n = 1'b1;

    // 512 x 0xFF with the matching CRC 0x7FA1, then a corrupted CRC.
    dq.delete();
    repeat (A_BYTES) dq.push_back(8'hFF);
    for (int pass = 0; pass < 2; pass++) begin
      sbits.delete();
      put_block(3, dq, (pass == 0) ? 16'h0000 : 16'h0001);
      chk("all_ff_crc_value", {win(sbits.size() - 16), win(sbits.size() - 8)},
          (pass == 0) ? 16'h7FA1 : 16'h7FA0);
      start(0, 1'b0, e0);
      model(0, 0, e0, -1, dummy);
      drive(0, -1, -1);
      drain(0, (pass == 0) ? "ff_good" : "ff_bad");
    end

    // Timeout: line held high for the whole hunt window.
    sbits.delete();
    start(0, 1'b0, e0);
    model(0, 0, e0, -1, dummy);
    drive(0, -1, -1);
    drain(0, "timeout_a");

    // Reset after byte 100, then a full block restarting at index 0.
    sbits.delete();
    put_block(3, dq, 16'h0000);
    start(0, 1'b0, e0);
    model(0, 0, e0, 100, dummy);
    drive(0, 100, -1);
    chk("reset_queue_empty", qa.size(), 0);
    start(0, 1'b0, e0);
    model(0, 0, e0, -1, dummy);
    drive(0, -1, -1);
    drain(0, "after_reset");

    // Back-to-back blocks with activate held high.
    dq = '{8'h01, 8'h02, 8'h03, 8'h04};
    sbits.delete();
    put_block(2, dq, 16'h0000);
    start(1, 1'b1, e0);
    model(1, 0, e0, -1, d1);
    s2 = d1 + 2 - e0;
    while (sbits.size() < s2) sbits.push_back(1'b1);
    put_block(0, dq, 16'h0000);
    model(1, s2, e0, -1, dummy);
    drive(1, -1, d1 + 1);
    set_act(1, 1'b0);
    drain(1, "b2b");

    // Stream 0xFF 0x7F 0xFE followed by a block.
    sbits.delete();
    put_byte(8'hFF);
    put_byte(8'h7F);
    put_block(0, dq, 16'h0000);
    start(1, 1'b0, e0);
    model(1, 0, e0, -1, dummy);
    drive(1, -1, -1);
    drain(1, "token_boundary");

    // Randomised preambles (may hide an early token or run out the hunt), data and CRC errors.
    for (int it = 0; it < 12; it++) begin
      sbits.delete();
      pre = $urandom_range(0, 70);
      ffcnt = $urandom_range(0, 1);
      repeat (pre) sbits.push_back($urandom_range(0, 7) != 0);
      if (it % 4 == 3) repeat (B_WAIT / 8 + 1) put_byte(8'hFF);
      dq.delete();
      repeat (B_BYTES) dq.push_back(8'($urandom_range(0, 255)));
      flip = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      put_block(ffcnt, dq, flip);
      start(1, 1'b0, e0);
      model(1, 0, e0, -1, dummy);
      drive(1, -1, -1);
      drain(1, "random_b");
    end

    chk("final_queue_a", qa.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
